// File: rtl/l2_port_arbiter_if.sv
// Bundle of the L1 requester, L1 response and L2 port signals around the arbiter.
// master = arbiter view, slave = environment view (caches + L2).
interface l2_port_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  modport master (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );

  modport slave (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin sharing of the single L2 line port between I-cache and D-cache misses.
// One transaction at a time: IDLE -> SERVE_x -> TURN -> IDLE.
module l2_port_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_port_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic req_i;
  logic req_d;

  assign req_i = bus.icache_read;
  assign req_d = bus.dcache_read | bus.dcache_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bus.l2_read     = 1'b0;
    bus.l2_write    = 1'b0;
    bus.icache_resp = 1'b0;
    bus.dcache_resp = 1'b0;

    case (state_q)
      IDLE: begin
        // I wins if alone, or if both ask and D had the previous grant.
        if (req_i && (!req_d || last_grant_q == GRANT_D)) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          op_write_d   = 1'b0;
          addr_d       = bus.icache_address;
          wdata_d      = bus.dcache_wdata;
        end else if (req_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          op_write_d   = bus.dcache_write;
          addr_d       = bus.dcache_address;
          wdata_d      = bus.dcache_wdata;
        end
      end
      SERVE_I: begin
        bus.l2_read     = 1'b1;
        bus.icache_resp = bus.l2_resp;
        if (bus.l2_resp) state_d = TURN;
      end
      SERVE_D: begin
        bus.l2_read     = ~op_write_q;
        bus.l2_write    = op_write_q;
        bus.dcache_resp = bus.l2_resp;
        if (bus.l2_resp) state_d = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.l2_address   = addr_q;
  assign bus.l2_wdata     = wdata_q;
  // Read data is unqualified; only the resp strobes mark it valid.
  assign bus.icache_rdata = bus.l2_rdata;
  assign bus.dcache_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a per-cycle vector table plus hand-written
// sequences for reset, simultaneous requests, round-robin fairness and abort.
module tb_l2_port_arbiter;

  localparam int LW = 128;
  localparam int AW = 16;
  localparam logic [LW-1:0] WDATA_PAT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  l2_port_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  l2_port_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ir, dr, dw, resp;
    logic [AW-1:0] ia, da;
    logic          x_rd, x_wr, x_ir, x_dr;
    logic [AW-1:0] x_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ir, logic dr, logic dw, logic resp,
                              logic [AW-1:0] ia, logic [AW-1:0] da,
                              logic x_rd, logic x_wr, logic x_ir, logic x_dr,
                              logic [AW-1:0] x_addr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.resp = resp; v.ia = ia; v.da = da;
    v.x_rd = x_rd; v.x_wr = x_wr; v.x_ir = x_ir; v.x_dr = x_dr; v.x_addr = x_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keeps the invariant "time = posedge + 1" between calls.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_read = 1'b0; bus.icache_address = '0;
    bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.l2_rdata = '0; bus.l2_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Returns at a negedge with a strobe visible, or flags a timeout.
  task automatic wait_strobe(input string name, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.l2_read || bus.l2_write) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no strobe expected strobe within 20 cycles", name);
    end
  endtask

  initial begin
    logic ok;
    logic [LW-1:0] rdat;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // ---- reset with random inputs ----
    #1;
    for (int c = 0; c < 4; c++) begin
      bus.icache_read    = 1'($urandom);
      bus.icache_address = AW'($urandom);
      bus.dcache_read    = 1'($urandom);
      bus.dcache_write   = 1'($urandom);
      bus.dcache_address = AW'($urandom);
      bus.dcache_wdata   = {$urandom, $urandom, $urandom, $urandom};
      bus.l2_resp        = 1'($urandom);
      @(negedge clk);
      chk("rst_l2_read",  LW'(bus.l2_read), '0);
      chk("rst_l2_write", LW'(bus.l2_write), '0);
      chk("rst_iresp",    LW'(bus.icache_resp), '0);
      chk("rst_dresp",    LW'(bus.dcache_resp), '0);
      chk("rst_addr",     LW'(bus.l2_address), '0);
      chk("rst_wdata",    bus.l2_wdata, '0);
      $display("reset cycle %0d: rd=%b wr=%b addr=%h", c, bus.l2_read, bus.l2_write, bus.l2_address);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;

    // ---- per-cycle vector table ----
    //             ir dr dw rs  ia        da        rd wr ir dr addr
    tbl.push_back(mk(1,0,0,0, 16'h1230, 16'h0000, 0,0,0,0, 16'h0000));
    tbl.push_back(mk(1,0,0,0, 16'h1230, 16'h0000, 1,0,0,0, 16'h1230));
    tbl.push_back(mk(1,0,0,0, 16'h1230, 16'h0000, 1,0,0,0, 16'h1230));
    tbl.push_back(mk(1,0,0,1, 16'h1230, 16'h0000, 1,0,1,0, 16'h1230));
    tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0, 16'h1230));
    tbl.push_back(mk(0,0,0,1, 16'h0000, 16'h0000, 0,0,0,0, 16'h1230));
    tbl.push_back(mk(0,1,0,0, 16'h0000, 16'h2000, 0,0,0,0, 16'h1230));
    tbl.push_back(mk(0,1,0,0, 16'h0000, 16'h2000, 1,0,0,0, 16'h2000));
    tbl.push_back(mk(0,1,0,0, 16'h0000, 16'h3FF0, 1,0,0,0, 16'h2000));
    tbl.push_back(mk(0,0,0,1, 16'h0000, 16'h3FF0, 1,0,0,1, 16'h2000));
    tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0, 16'h2000));
    tbl.push_back(mk(1,0,1,0, 16'h5550, 16'h4440, 0,0,0,0, 16'h2000));
    tbl.push_back(mk(1,0,1,0, 16'h5550, 16'h4440, 1,0,0,0, 16'h5550));
    tbl.push_back(mk(1,0,1,1, 16'h5550, 16'h4440, 1,0,1,0, 16'h5550));
    tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h4440, 0,0,0,0, 16'h5550));
    tbl.push_back(mk(0,0,1,0, 16'h0000, 16'h4440, 0,0,0,0, 16'h5550));
    tbl.push_back(mk(0,0,1,1, 16'h0000, 16'h4440, 0,1,0,1, 16'h4440));
    tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0, 16'h4440));
    tbl.push_back(mk(0,1,1,0, 16'h0000, 16'h6000, 0,0,0,0, 16'h4440));
    tbl.push_back(mk(0,1,1,0, 16'h0000, 16'h6000, 0,1,0,0, 16'h6000));
    tbl.push_back(mk(0,1,1,1, 16'h0000, 16'h6000, 0,1,0,1, 16'h6000));
    tbl.push_back(mk(0,0,0,1, 16'h0000, 16'h0000, 0,0,0,0, 16'h6000));
    tbl.push_back(mk(0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0, 16'h6000));
    tbl.push_back(mk(0,0,0,1, 16'h0000, 16'h0000, 0,0,0,0, 16'h6000));

    for (int i = 0; i < tbl.size(); i++) begin
      rdat = {8{16'(i * 16'h0101 + 16'h00A5)}};
      bus.icache_read    = tbl[i].ir;
      bus.icache_address = tbl[i].ia;
      bus.dcache_read    = tbl[i].dr;
      bus.dcache_write   = tbl[i].dw;
      bus.dcache_address = tbl[i].da;
      bus.l2_resp        = tbl[i].resp;
      bus.l2_rdata       = rdat;
      @(negedge clk);
      chk("vec_l2_read",  LW'(bus.l2_read),     LW'(tbl[i].x_rd));
      chk("vec_l2_write", LW'(bus.l2_write),    LW'(tbl[i].x_wr));
      chk("vec_iresp",    LW'(bus.icache_resp), LW'(tbl[i].x_ir));
      chk("vec_dresp",    LW'(bus.dcache_resp), LW'(tbl[i].x_dr));
      chk("vec_addr",     LW'(bus.l2_address),  LW'(tbl[i].x_addr));
      chk("vec_irdata",   bus.icache_rdata, rdat);
      chk("vec_drdata",   bus.dcache_rdata, rdat);
      $display("vec %0d: rd=%b wr=%b iresp=%b dresp=%b addr=%h", i, bus.l2_read,
               bus.l2_write, bus.icache_resp, bus.dcache_resp, bus.l2_address);
      next_cycle();
    end
    idle_inputs();

    // ---- simultaneous I-read and D-write straight after reset ----
    do_reset();
    bus.icache_read    = 1'b1; bus.icache_address = 16'h0040;
    bus.dcache_write   = 1'b1; bus.dcache_address = 16'h8000;
    bus.dcache_wdata   = WDATA_PAT;
    wait_strobe("sim_first", ok);
    if (ok) begin
      chk("sim_first_rd",   LW'(bus.l2_read), 1);
      chk("sim_first_wr",   LW'(bus.l2_write), 0);
      chk("sim_first_addr", LW'(bus.l2_address), LW'(16'h0040));
      bus.l2_resp = 1'b1;
      #1;
      chk("sim_first_iresp", LW'(bus.icache_resp), 1);
      chk("sim_first_dresp", LW'(bus.dcache_resp), 0);
      $display("sim first: rd=%b addr=%h iresp=%b", bus.l2_read, bus.l2_address, bus.icache_resp);
      next_cycle();
      bus.l2_resp = 1'b0;
      bus.icache_read = 1'b0;
    end
    wait_strobe("sim_second", ok);
    if (ok) begin
      chk("sim_second_wr",    LW'(bus.l2_write), 1);
      chk("sim_second_rd",    LW'(bus.l2_read), 0);
      chk("sim_second_addr",  LW'(bus.l2_address), LW'(16'h8000));
      chk("sim_second_wdata", bus.l2_wdata, WDATA_PAT);
      bus.l2_resp = 1'b1;
      #1;
      chk("sim_second_dresp", LW'(bus.dcache_resp), 1);
      chk("sim_second_iresp", LW'(bus.icache_resp), 0);
      $display("sim second: wr=%b addr=%h wdata=%h", bus.l2_write, bus.l2_address, bus.l2_wdata);
      next_cycle();
      bus.l2_resp = 1'b0;
    end
    idle_inputs();

    // ---- continuous I and D reads: grants alternate I, D, I, ... ----
    do_reset();
    bus.icache_read = 1'b1; bus.icache_address = 16'h0100;
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h0200;
    for (int t = 0; t < 6; t++) begin
      wait_strobe("rr_strobe", ok);
      if (!ok) break;
      chk("rr_addr", LW'(bus.l2_address), (t % 2 == 0) ? LW'(16'h0100) : LW'(16'h0200));
      bus.l2_resp = 1'b1;
      #1;
      chk("rr_iresp", LW'(bus.icache_resp), LW'(t % 2 == 0));
      chk("rr_dresp", LW'(bus.dcache_resp), LW'(t % 2 == 1));
      $display("rr txn %0d: iresp=%b dresp=%b addr=%h", t, bus.icache_resp, bus.dcache_resp, bus.l2_address);
      next_cycle();
      bus.l2_resp = 1'b0;
    end
    idle_inputs();

    // ---- reset asserted in the middle of a write ----
    do_reset();
    bus.dcache_write = 1'b1; bus.dcache_address = 16'h9000; bus.dcache_wdata = WDATA_PAT;
    wait_strobe("abort_strobe", ok);
    if (ok) begin
      chk("abort_pre_wr", LW'(bus.l2_write), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_wr",    LW'(bus.l2_write), 0);
      chk("abort_rd",    LW'(bus.l2_read), 0);
      chk("abort_addr",  LW'(bus.l2_address), '0);
      chk("abort_wdata", bus.l2_wdata, '0);
      $display("abort: wr=%b rd=%b addr=%h", bus.l2_write, bus.l2_read, bus.l2_address);
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rd",    LW'(bus.l2_read), 0);
      chk("post_wr",    LW'(bus.l2_write), 0);
      chk("post_iresp", LW'(bus.icache_resp), 0);
      chk("post_dresp", LW'(bus.dcache_resp), 0);
      $display("post-reset cycle %0d: rd=%b wr=%b", c, bus.l2_read, bus.l2_write);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 line port (128-bit line, 16-bit address) between the I-cache miss path and the D-cache miss/writeback path.
- Arbitrates round-robin and captures the winning request's address and write data.
- Sequences one L2 transaction at a time, then routes `l2_resp` back to the winner only.
- Sits between the L1 cache controllers and the L2 cache. The L1 word extraction remains downstream of this block.

Parameters:
- `LINE_WIDTH`, 128, width of one cache line in bits.
- `ADDR_WIDTH`, 16, byte address width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_read`  in  1  I-cache line read request; held until `icache_resp`.
- `icache_address`  in  `ADDR_WIDTH`  I-cache line address.
- `icache_rdata`  out  `LINE_WIDTH`  line returned to the I-cache.
- `icache_resp`  out  1  I-cache transaction complete.
- `dcache_read`  in  1  D-cache line read request; held until `dcache_resp`.
- `dcache_write`  in  1  D-cache line writeback request; held until `dcache_resp`.
- `dcache_address`  in  `ADDR_WIDTH`  D-cache line address.
- `dcache_wdata`  in  `LINE_WIDTH`  writeback line.
- `dcache_rdata`  out  `LINE_WIDTH`  line returned to the D-cache.
- `dcache_resp`  out  1  D-cache transaction complete.
- `l2_read`  out  1  L2 read strobe.
- `l2_write`  out  1  L2 write strobe.
- `l2_address`  out  `ADDR_WIDTH`  latched address.
- `l2_wdata`  out  `LINE_WIDTH`  latched write data.
- `l2_rdata`  in  `LINE_WIDTH`  L2 read data.
- `l2_resp`  in  1  L2 transaction complete; valid for one cycle.

Behaviour:
- **Reset** (`rst_n`=0, asynchronous): state=IDLE, `last_grant`=D.
  - All outputs are 0: strobes, resps, `l2_address`, `l2_wdata`.
  - `icache_rdata` and `dcache_rdata` are wires from `l2_rdata`, so they are not reset.
- **Reset mid-transaction:** the transaction is abandoned and the strobes drop immediately. Requesters must re-request after reset is released.
- **States:** IDLE, SERVE_I, SERVE_D, TURN.
- **IDLE arbitration:**
  - `req_i` = `icache_read`; `req_d` = `dcache_read` | `dcache_write`.
  - Only one request present → grant it.
  - Both present → grant the one not equal to `last_grant` (round-robin).
  - On grant: register address, `dcache_wdata` and the op (write if `dcache_write`, else read), update `last_grant`, and move to SERVE_x on the next edge.
  - Grant latency is 1 cycle: the strobe is asserted in the cycle after the request is first seen in IDLE.
- **SERVE_x:**
  - `l2_read` / `l2_write` is asserted from the registered op, decoded from state (glitch-free, no dependence on live requester inputs).
  - `l2_address` / `l2_wdata` hold their latched values for the whole transaction.
- **Response routing:** when `l2_resp`=1 in SERVE_x:
  - The matching `icache_resp` / `dcache_resp` = 1 combinationally, in the same cycle.
  - The non-granted resp stays 0.
  - Next state is TURN.
- **TURN:** exactly one cycle with strobes low and resps low, so requesters can drop or change their request. Then IDLE.
- Minimum request-to-request spacing is therefore IDLE → SERVE → TURN, i.e. at least 3 cycles per transaction.
- **Data paths:** `icache_rdata` = `dcache_rdata` = `l2_rdata` unconditionally. Only the resp qualifies them.
- **Simultaneous `dcache_read` and `dcache_write`** is illegal from the requester. The arbiter treats it as a write.
- **Requester drops its request during SERVE:** the transaction still completes with L2. The resp is still pulsed.
- **`l2_resp` in IDLE or TURN:** ignored, with no state change.
- **Starvation:** round-robin bounds the wait to one foreign transaction.

Test Plan:
- Reset: hold `rst_n`=0 with random inputs → all strobes, resps, `l2_address` and `l2_wdata` are 0; after release the state is IDLE.
- Lone I-read of 0x1230 at cycle 0:
  - cycles 1–3: `l2_read`=1, `l2_address`=0x1230.
  - `l2_resp` at cycle 3: `icache_resp`=1 in cycle 3 with `icache_rdata`=`l2_rdata`, `dcache_resp`=0.
  - cycle 4: TURN (all 0).
- Simultaneous I-read 0x0040 and D-write 0x8000 (wdata = 128'hDEAD…BEEF) straight after reset:
  - I is granted first, since `last_grant`=D.
  - The D write follows with `l2_write`=1, `l2_address`=0x8000 and the exact `l2_wdata`.
- Continuous I and D requests over 6 transactions: the grants alternate I, D, I, D, I, D.
- The D-read requester changes `dcache_address` mid-SERVE: `l2_address` keeps the latched value.
- `rst_n` asserted while `l2_write`=1: strobes drop asynchronously. After release, with no request pending, there are no strobes and no resps.
